// File: rtl/vsru_sched_pkg.sv
// rtl/vsru_sched_pkg.sv - shared types and config field positions for the chain scheduler
package vsru_sched_pkg;

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} sched_state_t;

    typedef struct packed {
        logic       enable;
        logic [3:0] burst;
    } cfg_t;

    localparam int CFG_EN_BIT    = 0;
    localparam int CFG_BURST_LSB = 4;
    localparam int CFG_UNIT_LSB  = 4;

endpackage

// File: rtl/vsru_chain_scheduler_if.sv
// rtl/vsru_chain_scheduler_if.sv - request/output/config bundle for the scheduler; perf ports under VSRU_SCHED_PERF_CNT_EN
interface vsru_chain_scheduler_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_CHAINS = 4
);
    localparam int CHAIN_W = $clog2(MAX_CHAINS);

    logic                                           tracing;
    logic [7:0]                                     config_id;
    logic [7:0]                                     config_data;
    logic [MAX_CHAINS-1:0]                          req_valid;
    logic [MAX_CHAINS-1:0]                          req_eof;
    logic [MAX_CHAINS-1:0][N-1:0][DATA_WIDTH-1:0]   req_vector;
    logic [MAX_CHAINS-1:0]                          req_ready;
    logic                                           out_ready;
    logic                                           valid_out;
    logic                                           eof_out;
    logic [CHAIN_W-1:0]                             chainId_out;
    logic [N-1:0][DATA_WIDTH-1:0]                   vector_out;
    logic                                           busy;
`ifdef VSRU_SCHED_PERF_CNT_EN
    logic [CHAIN_W-1:0]                             perf_sel;
    logic [31:0]                                    perf_cnt;
`endif

    modport master (
        output tracing, config_id, config_data, req_valid, req_eof, req_vector, out_ready,
        input  req_ready, valid_out, eof_out, chainId_out, vector_out, busy
`ifdef VSRU_SCHED_PERF_CNT_EN
        , output perf_sel, input perf_cnt
`endif
    );

    modport slave (
        input  tracing, config_id, config_data, req_valid, req_eof, req_vector, out_ready,
        output req_ready, valid_out, eof_out, chainId_out, vector_out, busy
`ifdef VSRU_SCHED_PERF_CNT_EN
        , input perf_sel, output perf_cnt
`endif
    );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: lowest requesting index at or after ptr
module rr_arbiter
    import vsru_sched_pkg::*;
#(
    parameter int REQS = 4,
    localparam int W   = $clog2(REQS)
) (
    input  logic [REQS-1:0] req,
    input  logic [W-1:0]    ptr,
    output logic [REQS-1:0] gnt,
    output logic [W-1:0]    gnt_idx,
    output logic            hit
);

    logic [W-1:0] idx;

    // Scanning from the farthest offset down leaves the nearest requester as the final winner.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        idx     = '0;
        for (int i = REQS - 1; i >= 0; i--) begin
            idx = ptr + W'(i);
            if (req[idx]) begin
                hit     = 1'b1;
                gnt_idx = idx;
            end
        end
        if (hit) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/vsru_chain_scheduler.sv
// rtl/vsru_chain_scheduler.sv - frame-locked round-robin scheduler feeding the shared reduce unit; VSRU_SCHED_PERF_CNT_EN adds stall counters
module vsru_chain_scheduler
    import vsru_sched_pkg::*;
#(
    parameter int         N          = 8,
    parameter int         DATA_WIDTH = 32,
    parameter int         MAX_CHAINS = 4,
    parameter logic [3:0] UNIT_ID    = 4'h2
) (
    input logic                     clk,
    input logic                     rst_n,
    vsru_chain_scheduler_if.slave   bus
);

    localparam int CHAIN_W = $clog2(MAX_CHAINS);
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_LOCK = LOCK;

    logic [0:0]                     state;
    logic [CHAIN_W-1:0]             g;
    logic [CHAIN_W-1:0]             rr_ptr;
    logic [CHAIN_W-1:0]             arb_idx;
    logic [CHAIN_W-1:0]             cfg_idx;
    logic [MAX_CHAINS-1:0]          gnt_q;
    logic [MAX_CHAINS-1:0]          arb_gnt;
    logic [MAX_CHAINS-1:0]          req_en;
    logic                           arb_hit;
    logic [3:0]                     beat_cnt;
    logic [3:0]                     beat_nxt;
    cfg_t                           cfg [MAX_CHAINS];
    logic                           cfg_we;
    logic                           cfg_unused;
    logic                           accept;
    logic                           frame_end;
    logic                           out_free;
    logic                           valid_q;
    logic                           eof_q;
    logic [CHAIN_W-1:0]             chain_q;
    logic [N-1:0][DATA_WIDTH-1:0]   vector_q;

    always_comb begin
        req_en = '0;
        for (int c = 0; c < MAX_CHAINS; c++) req_en[c] = bus.req_valid[c] & cfg[c].enable;
    end

    rr_arbiter #(.REQS(MAX_CHAINS)) u_arb (
        .req     (req_en),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx),
        .hit     (arb_hit)
    );

    // Ready looks through the output register so back-to-back beats flow without a bubble.
    assign out_free      = ~valid_q | bus.out_ready;
    assign bus.req_ready = (state == ST_LOCK && out_free) ? gnt_q : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign beat_nxt      = beat_cnt + 4'd1;
    assign frame_end     = (accept && (bus.req_eof[g] ||
                           (cfg[g].burst != 4'd0 && beat_nxt >= cfg[g].burst))) || !cfg[g].enable;

    assign cfg_idx    = bus.config_id[CHAIN_W-1:0];
    assign cfg_we     = !bus.tracing && bus.config_id[CFG_UNIT_LSB +: 4] == UNIT_ID &&
                        {1'b0, bus.config_id[3:0]} < 5'(MAX_CHAINS);
    assign cfg_unused = ^bus.config_data[3:1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            g        <= '0;
            gnt_q    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
            valid_q  <= 1'b0;
            eof_q    <= 1'b0;
            chain_q  <= '0;
            vector_q <= '0;
            for (int c = 0; c < MAX_CHAINS; c++) cfg[c] <= '0;
        end else begin
            if (cfg_we) begin
                cfg[cfg_idx] <= '{enable: bus.config_data[CFG_EN_BIT],
                                  burst:  bus.config_data[CFG_BURST_LSB +: 4]};
            end

            if (accept) begin
                valid_q  <= 1'b1;
                eof_q    <= bus.req_eof[g];
                chain_q  <= g;
                vector_q <= bus.req_vector[g];
            end else if (bus.out_ready) begin
                valid_q <= 1'b0;
            end

            if (state == ST_IDLE) begin
                if (arb_hit) begin
                    state    <= ST_LOCK;
                    g        <= arb_idx;
                    gnt_q    <= arb_gnt;
                    beat_cnt <= '0;
                end
            end else if (frame_end) begin
                state    <= ST_IDLE;
                gnt_q    <= '0;
                rr_ptr   <= g + CHAIN_W'(1);
                beat_cnt <= '0;
            end else if (accept) begin
                beat_cnt <= beat_nxt;
            end
        end
    end

    assign bus.valid_out   = valid_q;
    assign bus.eof_out     = eof_q;
    assign bus.chainId_out = chain_q;
    assign bus.vector_out  = vector_q;
    assign bus.busy        = (state != ST_IDLE) | valid_q;

`ifdef VSRU_SCHED_PERF_CNT_EN
    logic [31:0] stall_cnt [MAX_CHAINS];
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < MAX_CHAINS; c++) stall_cnt[c] <= '0;
            perf_q <= '0;
        end else begin
            for (int c = 0; c < MAX_CHAINS; c++) begin
                if (cfg_we && cfg_idx == CHAIN_W'(c)) begin
                    stall_cnt[c] <= '0;
                end else if (bus.req_valid[c] && !bus.req_ready[c] && stall_cnt[c] != '1) begin
                    stall_cnt[c] <= stall_cnt[c] + 32'd1;
                end
            end
            perf_q <= stall_cnt[bus.perf_sel];
        end
    end

    assign bus.perf_cnt = perf_q;
`endif

endmodule

// File: tb/tb_vsru_chain_scheduler.sv
// tb/tb_vsru_chain_scheduler.sv - directed and randomized bench with a frame-order reference model
module tb_vsru_chain_scheduler;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int MC    = 4;
    localparam int VW    = N * DW;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    vsru_chain_scheduler_if #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC)) bus ();

    vsru_chain_scheduler #(.N(N), .DATA_WIDTH(DW), .MAX_CHAINS(MC), .UNIT_ID(4'h2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] src_data [MC][DEPTH];
    bit            src_eof  [MC][DEPTH];
    int            src_len  [MC];
    int            src_rd   [MC];
    bit            src_on   [MC];

    bit m_en  [MC];
    int m_lim [MC];
    int m_ptr;
    int exp_ch [512];
    int exp_ix [512];
    int n_exp, n_obs;
    int obs_seq [$];

    bit            prev_stall;
    logic [VW-1:0] prev_vec;
    int            prev_ch;
    int            ready_pct;
    int            stall_left;

    task automatic check(string tag, logic [VW-1:0] got, logic [VW-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_src();
        bit v;
        for (int c = 0; c < MC; c++) begin
            v = src_on[c] && (src_rd[c] < src_len[c]);
            bus.req_valid[c]  = v;
            bus.req_eof[c]    = v ? src_eof[c][src_rd[c]] : 1'b0;
            bus.req_vector[c] = v ? src_data[c][src_rd[c]] : '0;
        end
    endtask

    task automatic clear_src();
        for (int c = 0; c < MC; c++) begin
            src_len[c] = 0;
            src_rd[c]  = 0;
            src_on[c]  = 1'b1;
        end
        prev_stall = 1'b0;
        drive_src();
    endtask

    task automatic add_frame(int c, int len);
        logic [VW-1:0] d;
        for (int i = 0; i < len; i++) begin
            for (int l = 0; l < N; l++) d[l*DW +: DW] = $urandom;
            src_data[c][src_len[c]] = d;
            src_eof[c][src_len[c]]  = (i == len - 1);
            src_len[c]++;
        end
    endtask

    // Reference: grant the nearest enabled chain with data, stream until eof or limit, move pointer past it.
    task automatic model_build();
        int  rd [MC];
        int  c, cnt, cand;
        bit  found, last;
        for (int k = 0; k < MC; k++) rd[k] = src_rd[k];
        n_exp = 0;
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            c = 0;
            for (int k = 0; k < MC; k++) begin
                cand = (m_ptr + k) % MC;
                if (!found && src_on[cand] && m_en[cand] && rd[cand] < src_len[cand]) begin
                    found = 1'b1;
                    c = cand;
                end
            end
            if (found) begin
                cnt = 0;
                do begin
                    exp_ch[n_exp] = c;
                    exp_ix[n_exp] = rd[c];
                    n_exp++;
                    last = src_eof[c][rd[c]];
                    rd[c]++;
                    cnt++;
                end while (!last && !(m_lim[c] != 0 && cnt >= m_lim[c]));
                m_ptr = (c + 1) % MC;
            end
        end
    endtask

    task automatic cfg_write(logic [7:0] id, logic [7:0] data, logic trace);
        bus.tracing     = trace;
        bus.config_id   = id;
        bus.config_data = data;
        @(posedge clk); #1;
        bus.tracing     = 1'b0;
        bus.config_id   = 8'h00;
        bus.config_data = 8'h00;
        prev_stall      = 1'b0;
        if (!trace && id[7:4] == 4'h2 && id[3:0] < MC) begin
            m_en[id[1:0]]  = data[0];
            m_lim[id[1:0]] = int'(data[7:4]);
        end
    endtask

    task automatic cycle();
        logic [MC-1:0] acc;
        int e;
        @(negedge clk);
        if (prev_stall) begin
            check("stall_valid", bus.valid_out, 1);
            check("stall_vector", bus.vector_out, prev_vec);
            check("stall_chain", bus.chainId_out, prev_ch);
        end
        if (bus.valid_out && !bus.out_ready) check("stall_req_ready", bus.req_ready, 0);
        check("req_ready_onehot", $onehot0(bus.req_ready), 1);
        check("busy_vs_valid", bus.busy | !bus.valid_out, 1);
        if (bus.valid_out && bus.out_ready) begin
            if (n_obs < n_exp) begin
                e = exp_ch[n_obs];
                check("beat_chain", bus.chainId_out, e);
                check("beat_eof", bus.eof_out, src_eof[e][exp_ix[n_obs]]);
                check("beat_data", bus.vector_out, src_data[e][exp_ix[n_obs]]);
            end else begin
                check("extra_beat", bus.valid_out & bus.out_ready, 0);
            end
            obs_seq.push_back(int'(bus.chainId_out));
            n_obs++;
        end
        prev_stall = bus.valid_out && !bus.out_ready;
        prev_vec   = bus.vector_out;
        prev_ch    = int'(bus.chainId_out);
        acc        = bus.req_valid & bus.req_ready;
        @(posedge clk); #1;
        for (int c = 0; c < MC; c++) if (acc[c]) src_rd[c]++;
        drive_src();
        if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
        end else begin
            bus.out_ready = ($urandom_range(0, 99) < ready_pct);
        end
    endtask

    task automatic run_phase(int stall_at);
        int  budget;
        int  pct;
        bit  stalled;
        model_build();
        n_obs = 0;
        obs_seq.delete();
        budget = 0;
        stalled = 1'b0;
        while (n_obs < n_exp && budget < 3000) begin
            if (stall_at >= 0 && n_obs == stall_at && !stalled) begin
                stall_left = 4;
                stalled = 1'b1;
            end
            cycle();
            budget++;
        end
        check("phase_beats", n_obs, n_exp);
        pct = ready_pct;
        ready_pct = 100;
        repeat (6) cycle();
        ready_pct = pct;
        check("phase_idle", bus.busy, 0);
    endtask

    function automatic int seq_code();
        int code = 0;
        foreach (obs_seq[i]) code = code * 10 + obs_seq[i] + 1;
        return code;
    endfunction

    initial begin
        #5000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst_n           = 1'b0;
        bus.tracing     = 1'b0;
        bus.config_id   = 8'h00;
        bus.config_data = 8'h00;
        bus.req_valid   = '1;
        bus.req_eof     = '0;
        bus.req_vector  = '0;
        bus.out_ready   = 1'b1;
`ifdef VSRU_SCHED_PERF_CNT_EN
        bus.perf_sel    = '0;
`endif
        ready_pct  = 70;
        stall_left = 0;
        prev_stall = 1'b0;
        m_ptr      = 0;
        for (int c = 0; c < MC; c++) begin
            m_en[c]  = 1'b0;
            m_lim[c] = 0;
        end

        // Reset with all requests raised; nothing granted until chains are enabled.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("dis_req_ready", bus.req_ready, 0);
            check("dis_busy", bus.busy, 0);
            check("dis_chain", bus.chainId_out, 0);
        end
        @(posedge clk); #1;
        clear_src();

        // Two simultaneous full frames, no limit.
        for (int c = 0; c < MC; c++) cfg_write(8'h20 | 8'(c), 8'h01, 1'b0);
        add_frame(1, 3);
        add_frame(2, 3);
        drive_src();
        run_phase(-1);
        check("order_frames", seq_code(), 222333);

        // Park the pointer at chain 0, then burst-limited chain 0 against chain 3.
        clear_src();
        add_frame(3, 1);
        drive_src();
        run_phase(-1);
        clear_src();
        cfg_write(8'h20, 8'h21, 1'b0);
        add_frame(0, 5);
        add_frame(3, 2);
        drive_src();
        run_phase(-1);
        check("order_burst", seq_code(), 1144111);

        // Four-cycle output stall mid-frame.
        clear_src();
        cfg_write(8'h20, 8'h01, 1'b0);
        ready_pct = 100;
        add_frame(1, 6);
        drive_src();
        run_phase(2);
        ready_pct = 70;

        // Ignored writes: while tracing, wrong unit, chain index out of range.
        clear_src();
        cfg_write(8'h21, 8'h00, 1'b1);
        cfg_write(8'h11, 8'h00, 1'b0);
        cfg_write(8'h24, 8'h00, 1'b0);
        add_frame(1, 2);
        add_frame(0, 2);
        drive_src();
        run_phase(-1);

        // Effective disable of chain 1.
        clear_src();
        cfg_write(8'h21, 8'h00, 1'b0);
        add_frame(1, 3);
        add_frame(0, 1);
        add_frame(2, 2);
        drive_src();
        run_phase(-1);
        check("ch1_never_granted", src_rd[1], 0);

        // Reset on beat 2 of a 4-beat frame.
        clear_src();
        ready_pct = 100;
        add_frame(2, 4);
        drive_src();
        model_build();
        n_obs = 0;
        budget = 0;
        while (n_obs < 2 && budget < 200) begin
            cycle();
            budget++;
        end
        check("pre_reset_beats", n_obs, 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_valid_out", bus.valid_out, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_req_ready", bus.req_ready, 0);
        check("midrst_chain", bus.chainId_out, 0);
        check("midrst_vector", bus.vector_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ptr = 0;
        for (int c = 0; c < MC; c++) begin
            m_en[c]  = 1'b0;
            m_lim[c] = 0;
        end
        clear_src();
        for (int c = 0; c < MC; c++) cfg_write(8'h20 | 8'(c), 8'h01, 1'b0);
        add_frame(2, 2);
        add_frame(0, 2);
        add_frame(3, 1);
        drive_src();
        run_phase(-1);
        check("order_after_reset", seq_code(), 11334);

        // Randomized frames, enables, burst limits and backpressure.
        repeat (5) begin
            clear_src();
            for (int c = 0; c < MC; c++) begin
                cfg_write(8'h20 | 8'(c),
                          {4'($urandom_range(0, 3)), 3'b000, 1'($urandom_range(0, 99) < 80)}, 1'b0);
                repeat ($urandom_range(1, 3)) add_frame(c, $urandom_range(1, 5));
            end
            ready_pct = $urandom_range(40, 100);
            drive_src();
            run_phase(-1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
